key_pulse_conditioner: RTL and testbench

- Conditions one raw mechanical key input into clean single-cycle pulses that drive the `enable` input of a downstream modulo counter. A press advances the counter once; a held key advances it repeatedly.
- Contains a 2-flop synchroniser, a debounce filter, and a press/hold/auto-repeat state machine.
- Sits between board key pins and the counter stages.

---
 rtl/key_pulse_conditioner.sv | 124 ++++++++++++
 tb/tb_key_pulse_conditioner.sv | 114 +++++++++++
 2 files changed

// File: rtl/key_pulse_conditioner.sv
// Turns a raw mechanical key into debounced level, single-cycle press pulses
// and held-key auto-repeat pulses for a downstream counter enable.
//
//  state  | meaning
//  IDLE   | key released, waiting for the debounced press
//  HELD   | key pressed, timing the hold period before the first repeat
//  REPEAT | hold period elapsed, emitting one pulse every repeat period

module key_pulse_conditioner #(
    parameter int debounce_cycles = 20000,
    parameter int hold_cycles     = 10000000,
    parameter int repeat_cycles   = 2500000,
    parameter bit active_low_key  = 1'b1
) (
    input  logic clock,
    input  logic reset_n,
    input  logic key_raw,
    input  logic repeat_en,
    output logic level,
    output logic pulse,
    output logic long_press
);

    localparam int DW = $clog2(debounce_cycles + 1);
    localparam int HW = $clog2(hold_cycles + 1);
    localparam int RW = $clog2(repeat_cycles + 1);

    localparam logic [DW-1:0] DEB_LAST  = DW'(debounce_cycles - 1);
    localparam logic [HW-1:0] HOLD_LAST = HW'(hold_cycles - 1);
    localparam logic [RW-1:0] REP_LAST  = RW'(repeat_cycles - 1);
    localparam logic          RELEASED  = active_low_key;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        HELD   = 2'd1,
        REPEAT = 2'd2
    } state_t;

    state_t          state;
    logic            sync_a;
    logic            sync_b;
    logic            key_sync;
    logic [DW-1:0]   deb_cnt;
    logic [HW-1:0]   hold_cnt;
    logic [RW-1:0]   rep_cnt;
    logic            deb_flip;
    logic            rise;
    logic            fall;

    assign key_sync = active_low_key ? ~sync_b : sync_b;

    // The level toggles on the edge the counter would reach debounce_cycles,
    // so the FSM sees the edge on the same clock and pulse aligns with level.
    assign deb_flip = (key_sync != level) && (deb_cnt == DEB_LAST);
    assign rise     = deb_flip && !level;
    assign fall     = deb_flip && level;

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            sync_a     <= RELEASED;
            sync_b     <= RELEASED;
            deb_cnt    <= '0;
            level      <= 1'b0;
            pulse      <= 1'b0;
            long_press <= 1'b0;
            hold_cnt   <= '0;
            rep_cnt    <= '0;
            state      <= IDLE;
        end else begin
            sync_a <= key_raw;
            sync_b <= sync_a;

            if (key_sync == level || deb_flip) begin
                deb_cnt <= '0;
            end else begin
                deb_cnt <= deb_cnt + 1'b1;
            end

            if (deb_flip) begin
                level <= ~level;
            end

            pulse <= 1'b0;

            // Release wins over any hold or repeat pulse due on the same edge.
            if (fall) begin
                state      <= IDLE;
                long_press <= 1'b0;
                hold_cnt   <= '0;
                rep_cnt    <= '0;
            end else begin
                case (state)
                    IDLE: begin
                        if (rise) begin
                            pulse    <= 1'b1;
                            hold_cnt <= '0;
                            state    <= HELD;
                        end
                    end
                    HELD: begin
                        if (hold_cnt == HOLD_LAST) begin
                            long_press <= 1'b1;
                            pulse      <= repeat_en;
                            rep_cnt    <= '0;
                            state      <= REPEAT;
                        end else begin
                            hold_cnt <= hold_cnt + 1'b1;
                        end
                    end
                    REPEAT: begin
                        if (rep_cnt == REP_LAST) begin
                            pulse   <= repeat_en;
                            rep_cnt <= '0;
                        end else begin
                            rep_cnt <= rep_cnt + 1'b1;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_key_pulse_conditioner.sv
// Directed bench for key_pulse_conditioner with short debounce/hold/repeat
// settings; expected outputs follow hand-derived cycle formulas.

module tb_key_pulse_conditioner;

    localparam int DEB  = 4;
    localparam int HOLD = 10;
    localparam int REP  = 3;
    localparam int NONE = 1000;

    logic clock;
    logic reset_n;
    logic key_raw;
    logic repeat_en;
    logic level;
    logic pulse;
    logic long_press;

    int total = 0;
    int bad   = 0;

    key_pulse_conditioner #(
        .debounce_cycles (DEB),
        .hold_cycles     (HOLD),
        .repeat_cycles   (REP),
        .active_low_key  (1'b1)
    ) dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .key_raw    (key_raw),
        .repeat_en  (repeat_en),
        .level      (level),
        .pulse      (pulse),
        .long_press (long_press)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input int c, input logic obs, input logic exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s c=%0d observed=%0b expected=%0b", tag, c, obs, exp);
        end
    endtask

    // {level, pulse, long_press} for one press that rises at r and falls at f.
    function automatic logic [2:0] model(input int c, input int r, input int f, input bit rep);
        logic lv, pl, lp;
        lv = (c >= r) && (c < f);
        lp = (c >= r + HOLD) && (c < f);
        pl = (c == r) || (rep && lp && ((c - r - HOLD) % REP == 0));
        return {lv, pl, lp};
    endfunction

    task automatic run(input string tag, input int rel_c, input int rst_c, input int last_c,
                       input int r1, input int f1, input int r2, input int f2, input bit rep);
        logic [2:0] e;
        for (int c = 0; c <= last_c; c++) begin
            e = model(c, r1, f1, rep) | model(c, r2, f2, rep);
            chk({tag, ".level"}, c, level, e[2]);
            chk({tag, ".pulse"}, c, pulse, e[1]);
            chk({tag, ".long"},  c, long_press, e[0]);
            key_raw   = (c < rel_c) ? 1'b0 : 1'b1;
            reset_n   = (rst_c >= 0 && c >= rst_c && c < rst_c + 2) ? 1'b0 : 1'b1;
            repeat_en = rep;
            tick();
        end
    endtask

    initial begin
        reset_n   = 1'b0;
        key_raw   = 1'b1;
        repeat_en = 1'b1;
        tick();
        for (int c = 0; c < 3; c++) begin
            chk("rst.level", c, level, 1'b0);
            chk("rst.pulse", c, pulse, 1'b0);
            chk("rst.long",  c, long_press, 1'b0);
            tick();
        end
        reset_n = 1'b1;
        for (int c = 0; c < 6; c++) begin
            tick();
            chk("post_rst.level", c, level, 1'b0);
            chk("post_rst.pulse", c, pulse, 1'b0);
            chk("post_rst.long",  c, long_press, 1'b0);
        end

        // short press: level rises at 6, falls 6 cycles after release at 8
        run("tap", 8, -1, 20, 6, 14, NONE, NONE, 1'b1);
        // glitch of debounce-1 sampled cycles never reaches level
        run("glitch", 3, -1, 15, NONE, NONE, NONE, NONE, 1'b1);
        // long hold with repeat; fall at 46 coincides with a due repeat pulse
        run("hold_rep", 40, -1, 52, 6, 46, NONE, NONE, 1'b1);
        // long hold without repeat
        run("hold_norep", 40, -1, 52, 6, 46, NONE, NONE, 1'b0);
        // release so level falls exactly where P+13 would pulse
        run("rel_prio", 13, -1, 25, 6, 19, NONE, NONE, 1'b1);
        // reset during REPEAT, key still held: outputs clear, then a fresh press
        run("rst_rep", 30, 20, 42, 6, 21, 28, 36, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
